// File: rtl/ex_mem_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: width defaults,
// redirect FSM encoding, the ID/EX control bundle and the MEM-stage controls.
package ex_mem_reg_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W_DEF  = 5;
    localparam int unsigned CNT_W_DEF  = 32;

    // Redirect sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } redir_state_e;

    // Control bundle produced by decode and carried through ID/EX
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic beq;
        logic bne;
        logic jump;
    } idex_ctrl_t;

    // Controls that survive into the MEM stage
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } mem_ctrl_t;

    // Branch/jump resolution; a jump wins over any branch kind
    function automatic logic branch_taken(input logic beq, input logic bne,
                                          input logic jump, input logic zero);
        return jump | (beq & zero) | (bne & ~zero);
    endfunction

endpackage

// File: rtl/ex_mem_reg_sat_free_counter.sv
// Free-running wrapping event counter.
// Ports: clk, rst (sync, active-high), inc (count enable), cnt (current value).
module sat_free_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wraps naturally modulo 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage MIPS core. Holds the EX results and
// controls for MEM, resolves beq/bne/jump and issues a one-shot PC redirect
// with an upstream flush, squashing the wrong-path instruction leaving EX.
// Ports: clk/rst (sync active-high); mem_stall freezes all state; ex_* inputs
// from ID/EX and the ALU; mem_* registered MEM-stage outputs; redirect,
// redirect_pc, flush_upstream; taken_cnt and squash_cnt performance counters.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_stall,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_beq,
    input  logic              ex_bne,
    input  logic              ex_jump,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_wreg,
    input  logic [DATA_W-1:0] ex_target,
    output logic              mem_valid,
    output logic              mem_regwrite,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_memtoreg,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_wreg,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              flush_upstream,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  squash_cnt
);

    redir_state_e      state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    mem_ctrl_t         mem_ctrl_q, mem_ctrl_d;
    logic [DATA_W-1:0] mem_alu_result_q, mem_alu_result_d;
    logic [DATA_W-1:0] mem_store_data_q, mem_store_data_d;
    logic [REG_W-1:0]  mem_wreg_q, mem_wreg_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              redirect_q, redirect_d;

    idex_ctrl_t        ex_ctrl_c;
    logic              capture_c;
    logic              squash_c;
    logic              take_c;
    logic              taken_inc_c;
    logic              squash_inc_c;

    // Next-state, capture and redirect sequencing
    always_comb begin
        state_d          = state_q;
        mem_valid_d      = mem_valid_q;
        mem_ctrl_d       = mem_ctrl_q;
        mem_alu_result_d = mem_alu_result_q;
        mem_store_data_d = mem_store_data_q;
        mem_wreg_d       = mem_wreg_q;
        redirect_pc_d    = redirect_pc_q;

        ex_ctrl_c = '{regwrite: ex_regwrite, memread: ex_memread,
                      memwrite: ex_memwrite, memtoreg: ex_memtoreg,
                      beq: ex_beq, bne: ex_bne, jump: ex_jump};

        capture_c = ~mem_stall;
        // The instruction in EX during the redirect cycle is on the wrong path
        squash_c  = (state_q == ST_FIRE);
        take_c    = ex_valid & ~squash_c
                  & branch_taken(ex_ctrl_c.beq, ex_ctrl_c.bne, ex_ctrl_c.jump, ex_zero);

        if (capture_c) begin
            mem_valid_d         = ex_valid & ~squash_c;
            mem_ctrl_d.regwrite = ex_ctrl_c.regwrite & mem_valid_d;
            mem_ctrl_d.memread  = ex_ctrl_c.memread  & mem_valid_d;
            mem_ctrl_d.memwrite = ex_ctrl_c.memwrite & mem_valid_d;
            mem_ctrl_d.memtoreg = ex_ctrl_c.memtoreg & mem_valid_d;
            mem_alu_result_d    = ex_alu_result;
            mem_store_data_d    = ex_store_data;
            mem_wreg_d          = ex_wreg;
            redirect_pc_d       = ex_target;
        end

        case (state_q)
            ST_IDLE: begin
                if (capture_c && take_c) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                // The pulse has already been seen; a stall parks in HOLD so it
                // is not repeated while MEM is frozen
                if (!capture_c) begin
                    state_d = ST_HOLD;
                end else if (take_c) begin
                    state_d = ST_FIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (capture_c) begin
                    state_d = take_c ? ST_FIRE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        redirect_d   = (state_d == ST_FIRE);
        taken_inc_c  = capture_c & take_c;
        squash_inc_c = ex_valid & squash_c & capture_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            mem_valid_q      <= 1'b0;
            mem_ctrl_q       <= '0;
            mem_alu_result_q <= '0;
            mem_store_data_q <= '0;
            mem_wreg_q       <= '0;
            redirect_pc_q    <= '0;
            redirect_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            mem_valid_q      <= mem_valid_d;
            mem_ctrl_q       <= mem_ctrl_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_store_data_q <= mem_store_data_d;
            mem_wreg_q       <= mem_wreg_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_q       <= redirect_d;
        end
    end

    sat_free_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk (clk),
        .rst (rst),
        .inc (taken_inc_c),
        .cnt (taken_cnt)
    );

    sat_free_counter #(.CNT_W(CNT_W)) u_squash_cnt (
        .clk (clk),
        .rst (rst),
        .inc (squash_inc_c),
        .cnt (squash_cnt)
    );

    assign mem_valid      = mem_valid_q;
    assign mem_regwrite   = mem_ctrl_q.regwrite;
    assign mem_memread    = mem_ctrl_q.memread;
    assign mem_memwrite   = mem_ctrl_q.memwrite;
    assign mem_memtoreg   = mem_ctrl_q.memtoreg;
    assign mem_alu_result = mem_alu_result_q;
    assign mem_store_data = mem_store_data_q;
    assign mem_wreg       = mem_wreg_q;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_upstream = redirect_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed vector table, hand sequences for counter wrap
// and reset-during-redirect, then randomized traffic against a reference model.
module tb_ex_mem_reg;

    localparam int unsigned CW = 4;
    localparam int          CMOD = 16;

    logic        clk;
    logic        rst, mem_stall, ex_valid;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic        ex_beq, ex_bne, ex_jump, ex_zero;
    logic [31:0] ex_alu_result, ex_store_data, ex_target;
    logic [4:0]  ex_wreg;
    logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
    logic [31:0] mem_alu_result, mem_store_data, redirect_pc;
    logic [4:0]  mem_wreg;
    logic        redirect, flush_upstream;
    logic [CW-1:0] taken_cnt, squash_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ex_mem_reg #(.DATA_W(32), .REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_zero(ex_zero),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_wreg(ex_wreg), .ex_target(ex_target),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_memtoreg(mem_memtoreg), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .mem_wreg(mem_wreg),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .flush_upstream(flush_upstream), .taken_cnt(taken_cnt),
        .squash_cnt(squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a redirect is a single pulse after any captured taken
    // instruction; the instruction captured while the pulse is high is dropped.
    logic        m_valid, m_rw, m_mr, m_mw, m_mtr, m_redir;
    logic [31:0] m_alu, m_sd, m_rpc;
    logic [4:0]  m_wreg;
    int          m_taken, m_squash;

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_redir = 0;
        m_alu = 0; m_sd = 0; m_rpc = 0; m_wreg = 0; m_taken = 0; m_squash = 0;
    endtask

    task automatic model_edge();
        logic wrong_path, v, tk;
        if (rst) begin
            model_reset();
        end else if (!mem_stall) begin
            wrong_path = m_redir;
            v  = ex_valid & ~wrong_path;
            tk = v & (ex_jump | (ex_beq & ex_zero) | (ex_bne & ~ex_zero));
            if (ex_valid && wrong_path) m_squash = (m_squash + 1) % CMOD;
            if (tk) m_taken = (m_taken + 1) % CMOD;
            m_valid = v;
            m_rw = ex_regwrite & v; m_mr = ex_memread & v;
            m_mw = ex_memwrite & v; m_mtr = ex_memtoreg & v;
            m_alu = ex_alu_result; m_sd = ex_store_data;
            m_wreg = ex_wreg; m_rpc = ex_target;
            m_redir = tk;
        end else begin
            m_redir = 0;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".mem_valid"},  64'(mem_valid),      64'(m_valid));
        chk({tag, ".regwrite"},   64'(mem_regwrite),   64'(m_rw));
        chk({tag, ".memread"},    64'(mem_memread),    64'(m_mr));
        chk({tag, ".memwrite"},   64'(mem_memwrite),   64'(m_mw));
        chk({tag, ".memtoreg"},   64'(mem_memtoreg),   64'(m_mtr));
        chk({tag, ".alu"},        64'(mem_alu_result), 64'(m_alu));
        chk({tag, ".store"},      64'(mem_store_data), 64'(m_sd));
        chk({tag, ".wreg"},       64'(mem_wreg),       64'(m_wreg));
        chk({tag, ".redirect"},   64'(redirect),       64'(m_redir));
        chk({tag, ".flush"},      64'(flush_upstream), 64'(m_redir));
        chk({tag, ".taken_cnt"},  64'(taken_cnt),      64'(m_taken));
        chk({tag, ".squash_cnt"}, 64'(squash_cnt),     64'(m_squash));
        if (m_redir) chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(m_rpc));
    endtask

    task automatic drive(input logic r, input logic st, input logic v, input logic rw,
                         input logic bq, input logic bn, input logic j, input logic z,
                         input logic [31:0] alu, input logic [4:0] wr, input logic [31:0] tgt);
        rst = r; mem_stall = st; ex_valid = v; ex_regwrite = rw;
        ex_memread = 0; ex_memwrite = 0; ex_memtoreg = 0;
        ex_beq = bq; ex_bne = bn; ex_jump = j; ex_zero = z;
        ex_alu_result = alu; ex_wreg = wr; ex_target = tgt;
        ex_store_data = $urandom;
    endtask

    typedef struct {
        logic r, st, v, rw, bq, bn, j, z;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [31:0] tgt;
        logic        e_valid, e_rw;
        logic [31:0] e_alu;
        logic [4:0]  e_wreg;
        logic        e_redir;
        logic [31:0] e_rpc;
        int          e_taken, e_squash;
    } vec_t;

    function automatic vec_t mk(input logic r, st, v, rw, bq, bn, j, z,
                                input logic [31:0] alu, input logic [4:0] wr,
                                input logic [31:0] tgt,
                                input logic ev, erw, input logic [31:0] ealu,
                                input logic [4:0] ewr, input logic erd,
                                input logic [31:0] erpc, input int et, es);
        vec_t x;
        x.r = r; x.st = st; x.v = v; x.rw = rw; x.bq = bq; x.bn = bn; x.j = j; x.z = z;
        x.alu = alu; x.wr = wr; x.tgt = tgt;
        x.e_valid = ev; x.e_rw = erw; x.e_alu = ealu; x.e_wreg = ewr;
        x.e_redir = erd; x.e_rpc = erpc; x.e_taken = et; x.e_squash = es;
        return x;
    endfunction

    vec_t tbl[13];

    initial begin
        //             r st v rw bq bn j z   alu       wr  tgt      | v rw alu       wr rd rpc      tk sq
        tbl[0]  = mk(1,0,1,1, 1,0,1,1, 32'hdeadbeef,5'd31,32'hffff0000, 0,0,32'h0,  5'd0,0,32'h0,   0,0);
        tbl[1]  = mk(1,1,1,1, 0,1,1,0, 32'hcafef00d,5'd17,32'h12345678, 0,0,32'h0,  5'd0,0,32'h0,   0,0);
        tbl[2]  = mk(0,0,1,1, 0,0,0,0, 32'h10,      5'd8, 32'h0,        1,1,32'h10, 5'd8,0,32'h0,   0,0);
        tbl[3]  = mk(0,0,1,0, 1,0,0,1, 32'h0,       5'd0, 32'h400,      1,0,32'h0,  5'd0,1,32'h400, 1,0);
        tbl[4]  = mk(0,0,1,1, 0,0,0,0, 32'h20,      5'd9, 32'h0,        0,0,32'h20, 5'd9,0,32'h0,   1,1);
        tbl[5]  = mk(0,0,1,0, 0,1,0,1, 32'h30,      5'd0, 32'h500,      1,0,32'h30, 5'd0,0,32'h0,   1,1);
        tbl[6]  = mk(0,0,1,0, 1,0,1,0, 32'h0,       5'd0, 32'h800,      1,0,32'h0,  5'd0,1,32'h800, 2,1);
        tbl[7]  = mk(0,0,0,0, 0,0,0,0, 32'h0,       5'd0, 32'h0,        0,0,32'h0,  5'd0,0,32'h0,   2,1);
        tbl[8]  = mk(0,0,1,0, 1,0,0,1, 32'h40,      5'd3, 32'h123,      1,0,32'h40, 5'd3,1,32'h123, 3,1);
        tbl[9]  = mk(0,1,1,1, 0,0,0,0, 32'h55,      5'd5, 32'h0,        1,0,32'h40, 5'd3,0,32'h0,   3,1);
        tbl[10] = mk(0,1,1,1, 0,0,0,0, 32'h55,      5'd5, 32'h0,        1,0,32'h40, 5'd3,0,32'h0,   3,1);
        tbl[11] = mk(0,1,1,1, 0,0,0,0, 32'h55,      5'd5, 32'h0,        1,0,32'h40, 5'd3,0,32'h0,   3,1);
        tbl[12] = mk(0,0,1,1, 0,0,0,0, 32'h55,      5'd5, 32'h0,        1,1,32'h55, 5'd5,0,32'h0,   3,1);

        model_reset();
        for (int i = 0; i < 13; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].r, tbl[i].st, tbl[i].v, tbl[i].rw, tbl[i].bq, tbl[i].bn,
                  tbl[i].j, tbl[i].z, tbl[i].alu, tbl[i].wr, tbl[i].tgt);
            step();
            chk({t, ".mem_valid"},  64'(mem_valid),      64'(tbl[i].e_valid));
            chk({t, ".regwrite"},   64'(mem_regwrite),   64'(tbl[i].e_rw));
            chk({t, ".alu"},        64'(mem_alu_result), 64'(tbl[i].e_alu));
            chk({t, ".wreg"},       64'(mem_wreg),       64'(tbl[i].e_wreg));
            chk({t, ".redirect"},   64'(redirect),       64'(tbl[i].e_redir));
            chk({t, ".flush"},      64'(flush_upstream), 64'(tbl[i].e_redir));
            chk({t, ".taken_cnt"},  64'(taken_cnt),      64'(tbl[i].e_taken));
            chk({t, ".squash_cnt"}, 64'(squash_cnt),     64'(tbl[i].e_squash));
            if (tbl[i].e_redir) chk({t, ".redirect_pc"}, 64'(redirect_pc), 64'(tbl[i].e_rpc));
        end

        // Counter wrap: taken_cnt is 3 here; 13 more jumps bring it to 16 == 0
        for (int i = 0; i < 13; i++) begin
            drive(0, 0, 1, 0, 0, 0, 1, 0, 32'h0, 5'd0, 32'h1000 + 32'(i));
            step();
            chk("wrap.redirect", 64'(redirect), 64'd1);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);
            step();
        end
        chk("wrap.taken_cnt", 64'(taken_cnt), 64'd0);
        check_model("wrap");

        // Reset while the redirect pulse is high
        drive(0, 0, 1, 1, 0, 0, 1, 0, 32'h77, 5'd7, 32'h2000);
        step();
        chk("rstfire.pre_redirect", 64'(redirect), 64'd1);
        drive(1, 1, 1, 1, 1, 1, 1, 1, 32'hffffffff, 5'd31, 32'hffffffff);
        step();
        chk("rstfire.redirect",   64'(redirect),   64'd0);
        chk("rstfire.taken_cnt",  64'(taken_cnt),  64'd0);
        chk("rstfire.squash_cnt", 64'(squash_cnt), 64'd0);
        chk("rstfire.mem_valid",  64'(mem_valid),  64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 59) == 0);
            mem_stall     = ($urandom_range(0, 3) == 0);
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_regwrite   = 1'($urandom);
            ex_memread    = 1'($urandom);
            ex_memwrite   = 1'($urandom);
            ex_memtoreg   = 1'($urandom);
            ex_beq        = ($urandom_range(0, 2) == 0);
            ex_bne        = ($urandom_range(0, 2) == 0);
            ex_jump       = ($urandom_range(0, 4) == 0);
            ex_zero       = 1'($urandom);
            ex_alu_result = $urandom;
            ex_store_data = $urandom;
            ex_wreg       = 5'($urandom);
            ex_target     = $urandom;
            step();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
